// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the hazard sequencer: FSM states, widths,
// and instruction field positions of the register operands.
package hazard_sequencer_pkg;

  localparam int ADDR_W  = 8;
  localparam int REG_W   = 3;
  localparam int STALL_W = 8;

  localparam int RS_LSB = 8;
  localparam int RS_MSB = 10;
  localparam int RD_LSB = 11;
  localparam int RD_MSB = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_sequencer_hazard_detect.sv
// RAW hazard comparator: the FD source register against the in-flight
// destinations held in the DX and XW slots (no regfile bypass).
module hazard_detect #(
  parameter int REG_W = hazard_sequencer_pkg::REG_W
) (
  input  logic             fd_v,
  input  logic [REG_W-1:0] fd_rs,
  input  logic             dx_v,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             xw_v,
  input  logic [REG_W-1:0] xw_rd,
  output logic             hazard
);

  assign hazard = fd_v & ((dx_v & (fd_rs == dx_rd)) | (xw_v & (fd_rs == xw_rd)));

endmodule

// File: rtl/hazard_sequencer.sv
// Run sequencer for a 3-slot in-order pipe: owns the PC, tracks slot valid
// bits and stalls fetch on RAW hazards until the producer leaves XW.
module hazard_sequencer #(
  parameter int ADDR_W = hazard_sequencer_pkg::ADDR_W,
  parameter int REG_W  = hazard_sequencer_pkg::REG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [REG_W-1:0]  fd_rs,
  input  logic [REG_W-1:0]  fd_rd,
  output logic [ADDR_W-1:0] address_imem,
  output logic              fd_we,
  output logic              dx_bubble,
  output logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic [7:0]        stall_cnt
);
  import hazard_sequencer_pkg::*;

  state_e              state;
  logic [ADDR_W-1:0]   pc, end_q;
  logic                fd_v, dx_v, xw_v;
  logic [REG_W-1:0]    dx_rd_q, xw_rd_q;
  logic [STALL_W-1:0]  stall_q;
  logic                hazard, fetch;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .fd_v  (fd_v),
    .fd_rs (fd_rs),
    .dx_v  (dx_v),
    .dx_rd (dx_rd_q),
    .xw_v  (xw_v),
    .xw_rd (xw_rd_q),
    .hazard(hazard)
  );

  assign fetch        = (state == RUN) & ~hazard;
  assign fd_we        = fetch;
  assign address_imem = pc;
  assign dx_bubble    = hazard | ~fd_v;
  assign wb_en        = xw_v;
  assign busy         = (state == RUN) | (state == DRAIN);
  assign done         = (state == DONE);
  assign stall_cnt    = stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      end_q   <= '0;
      fd_v    <= 1'b0;
      dx_v    <= 1'b0;
      xw_v    <= 1'b0;
      dx_rd_q <= '0;
      xw_rd_q <= '0;
      stall_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            pc      <= '0;
            end_q   <= end_addr;
            fd_v    <= 1'b0;
            dx_v    <= 1'b0;
            xw_v    <= 1'b0;
            stall_q <= '0;
          end
        end
        RUN, DRAIN: begin
          // XW always advances, so a stalled producer drains out of the way.
          xw_v    <= dx_v;
          xw_rd_q <= dx_rd_q;
          if (hazard) begin
            dx_v <= 1'b0;
            if (stall_q != '1) stall_q <= stall_q + 1'b1;
          end else begin
            dx_v    <= fd_v;
            dx_rd_q <= fd_rd;
            fd_v    <= (state == RUN);
          end
          if (fetch) begin
            pc <= pc + 1'b1;
            if (pc == end_q) state <= DRAIN;
          end
          // With FD and DX empty the last XW writeback is this cycle; the
          // pipe is fully empty on the edge that enters DONE.
          if (state == DRAIN && !fd_v && !dx_v) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
